// File: rtl/packet_arbiter.sv
// Four-port round-robin packet arbiter: a one-deep slot per input port feeding a
// single registered output stage, plus a saturating count of error responses.

module packet_arbiter_slot #(
    parameter int PKT_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [PKT_W-1:0] pkt_i,
    output logic             full_o,
    output logic [PKT_W-1:0] pkt_o
);
    logic             full_q, full_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;

    // load only happens when empty and clear only when full, so they never collide
    always_comb begin
        full_d = full_q;
        pkt_d  = pkt_q;
        if (clear_i) full_d = 1'b0;
        if (load_i) begin
            full_d = 1'b1;
            pkt_d  = pkt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            pkt_q  <= '0;
        end else begin
            full_q <= full_d;
            pkt_q  <= pkt_d;
        end
    end

    assign full_o = full_q;
    assign pkt_o  = pkt_q;
endmodule

module packet_arbiter #(
    parameter int PKT_W = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [PKT_W-1:0] in_pkt_port1,
    input  logic [PKT_W-1:0] in_pkt_port2,
    input  logic [PKT_W-1:0] in_pkt_port3,
    input  logic [PKT_W-1:0] in_pkt_port4,
    output logic [3:0]       in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PKT_W-1:0] out_pkt,
    output logic [1:0]       out_src,
    output logic [7:0]       err_cnt
);
    localparam int NUM_PORTS = 4;
    localparam int RESP_LO   = 32;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                          state_q, state_d;
    logic [NUM_PORTS-1:0][PKT_W-1:0] in_pkt, slot_pkt;
    logic [NUM_PORTS-1:0]            slot_full, slot_load, slot_clear;
    logic [1:0]                      last_grant_q, last_grant_d;
    logic [1:0]                      grant_idx, cand;
    logic                            grant_vld, out_free;
    logic [PKT_W-1:0]                out_pkt_q, out_pkt_d;
    logic [1:0]                      out_src_q, out_src_d;
    logic [7:0]                      err_cnt_q, err_cnt_d;

    assign in_pkt    = {in_pkt_port4, in_pkt_port3, in_pkt_port2, in_pkt_port1};
    assign in_ready  = ~slot_full;
    assign slot_load = in_valid & ~slot_full;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        packet_arbiter_slot #(.PKT_W(PKT_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (slot_load[i]),
            .clear_i (slot_clear[i]),
            .pkt_i   (in_pkt[i]),
            .full_o  (slot_full[i]),
            .pkt_o   (slot_pkt[i])
        );
    end

    // Search starts one past the previous winner and wraps; first full slot wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = last_grant_q + 2'(k);
            if (!grant_vld && slot_full[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign out_free = (state_q == IDLE) || out_ready;

    always_comb begin
        state_d      = state_q;
        out_pkt_d    = out_pkt_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        err_cnt_d    = err_cnt_q;
        slot_clear   = '0;
        if (out_free) begin
            if (grant_vld) begin
                state_d               = SEND;
                out_pkt_d             = slot_pkt[grant_idx];
                out_src_d             = grant_idx;
                last_grant_d          = grant_idx;
                slot_clear[grant_idx] = 1'b1;
                if (slot_pkt[grant_idx][RESP_LO+1:RESP_LO] != 2'b00 && err_cnt_q != 8'hFF)
                    err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // last_grant resets to port4 so port1 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_pkt_q    <= '0;
            out_src_q    <= '0;
            last_grant_q <= 2'd3;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_pkt_q    <= out_pkt_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_pkt   = out_pkt_q;
    assign out_src   = out_src_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter: a cycle-level reference model pushes expected grants into
// a queue; a negedge monitor pops on each output handshake and compares.
module tb_packet_arbiter;
    localparam int PKT_W = 36;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic [3:0]       in_valid = '0;
    logic [PKT_W-1:0] pk [4]   = '{default: '0};
    logic             out_ready = 1'b0;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [PKT_W-1:0] out_pkt;
    logic [1:0]       out_src;
    logic [7:0]       err_cnt;

    packet_arbiter #(.PKT_W(PKT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_pkt_port1 (pk[0]),
        .in_pkt_port2 (pk[1]),
        .in_pkt_port3 (pk[2]),
        .in_pkt_port4 (pk[3]),
        .in_ready     (in_ready),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_pkt      (out_pkt),
        .out_src      (out_src),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        int               src;
    } exp_t;

    exp_t             exp_q[$];
    logic [PKT_W-1:0] m_slot [4];
    bit               m_full [4];
    bit               m_valid = 1'b0;
    int               m_last  = 3;
    int               m_err   = 0;
    int               n_cmp   = 0;
    int               n_fail  = 0;
    int               hs_cnt  = 0;
    int               src_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
        m_valid = 1'b0;
        m_last  = 3;
        m_err   = 0;
    endtask

    // One clock edge of the behavioural model: output side first, then input capture
    // against the slot occupancy seen before the edge.
    task automatic model_step();
        bit   pre [4];
        bit   found;
        bit   free;
        int   w;
        exp_t e;
        free = !m_valid || out_ready;
        for (int i = 0; i < 4; i++) pre[i] = m_full[i];
        if (free) begin
            found = 1'b0;
            w     = 0;
            for (int k = 1; k <= 4; k++) begin
                int p;
                p = (m_last + k) % 4;
                if (!found && m_full[p]) begin
                    found = 1'b1;
                    w     = p;
                end
            end
            if (found) begin
                e.pkt = m_slot[w];
                e.src = w;
                exp_q.push_back(e);
                m_full[w] = 1'b0;
                m_last    = w;
                m_valid   = 1'b1;
                if (m_slot[w][33:32] != 2'b00 && m_err < 255) m_err++;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++)
            if (in_valid[i] && !pre[i]) begin
                m_full[i] = 1'b1;
                m_slot[i] = pk[i];
            end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
    end

    initial forever begin
        logic [3:0] er;
        exp_t       e;
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < 4; i++) er[i] = !m_full[i];
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("in_ready", 64'(in_ready), 64'(er));
            check("err_cnt", 64'(err_cnt), 64'(m_err));
            if (out_valid && out_ready) begin
                hs_cnt++;
                src_log.push_back(int'(out_src));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected output: got pkt %0h src %0d, expected none", out_pkt, out_src);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pkt", 64'(out_pkt), 64'(e.pkt));
                    check("out_src", 64'(out_src), 64'(e.src));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1: asserts reset between edges and releases it after the negedge.
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'hF);
        check("rst err_cnt", 64'(err_cnt), 64'd0);
        check("rst out_pkt", 64'(out_pkt), 64'd0);
        check("rst out_src", 64'(out_src), 64'd0);
        in_valid = '0;
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_out_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            cyc();
            n++;
        end
        check("wait out_valid", 64'(out_valid), 64'd1);
    endtask

    initial begin
        logic [PKT_W-1:0] a, a2, b;
        int hs0, n;

        #1 rst_n = 1'b0;
        #1;
        check("init out_valid", 64'(out_valid), 64'd0);
        check("init in_ready", 64'(in_ready), 64'hF);
        check("init err_cnt", 64'(err_cnt), 64'd0);
        check("init out_pkt", 64'(out_pkt), 64'd0);
        check("init out_src", 64'(out_src), 64'd0);
        #10 rst_n = 1'b1;
        cyc();

        // single packet from port3
        out_ready = 1'b1;
        pk[2]     = 36'h1_0000_ABCD;
        in_valid  = 4'b0100;
        cyc();
        in_valid = '0;
        check("single early valid", 64'(out_valid), 64'd0);
        check("single in_ready", 64'(in_ready), 64'b1011);
        cyc();
        check("single valid", 64'(out_valid), 64'd1);
        check("single pkt", 64'(out_pkt), 64'h1_0000_ABCD);
        check("single src", 64'(out_src), 64'd2);
        check("single err_cnt", 64'(err_cnt), 64'd1);
        cyc();
        check("single one cycle", 64'(out_valid), 64'd0);

        // round-robin from reset
        pulse_reset();
        cyc();
        for (int i = 0; i < 4; i++) pk[i] = {2'(i), 2'b00, 32'($urandom())};
        in_valid = 4'hF;
        cyc();
        in_valid = '0;
        src_log.delete();
        check("rr in_ready loaded", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("rr in_ready", 64'(in_ready), 64'((1 << (k + 1)) - 1));
        end
        cyc();
        check("rr count", 64'(src_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < src_log.size(); i++)
            check("rr src", 64'(src_log[i]), 64'(i));

        // backpressure with port1 and port2 loaded
        pulse_reset();
        cyc();
        out_ready = 1'b0;
        a  = {2'd0, 2'b01, 32'hAAAA_0001};
        a2 = {2'd2, 2'b00, 32'hAAAA_0002};
        b  = {2'd1, 2'b00, 32'hBBBB_0003};
        pk[0] = a;
        pk[1] = b;
        in_valid = 4'b0011;
        cyc();
        pk[0]    = a2;
        in_valid = 4'b0001;
        cyc();
        cyc();
        in_valid = '0;
        for (int k = 0; k < 5; k++) begin
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp out_pkt", 64'(out_pkt), 64'(a));
            check("bp out_src", 64'(out_src), 64'd0);
            check("bp in_ready", 64'(in_ready), 64'b1100);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        check("bp port2 pkt", 64'(out_pkt), 64'(b));
        check("bp port2 src", 64'(out_src), 64'd1);
        cyc();
        check("bp port1 again", 64'(out_pkt), 64'(a2));

        // fairness between port1 and port4
        pulse_reset();
        cyc();
        src_log.delete();
        in_valid = 4'b1001;
        repeat (20) begin
            pk[0] = {2'd0, 2'($urandom_range(0, 3)), 32'($urandom())};
            pk[3] = {2'd3, 2'($urandom_range(0, 3)), 32'($urandom())};
            cyc();
        end
        in_valid = '0;
        repeat (4) cyc();
        check("fair count", 64'(src_log.size() >= 10), 64'd1);
        for (int i = 0; i < src_log.size(); i++)
            check("fair src", 64'(src_log[i]), 64'((i % 2 == 0) ? 0 : 3));

        // err_cnt saturation
        pulse_reset();
        cyc();
        hs0      = hs_cnt;
        n        = 0;
        in_valid = 4'hF;
        while (hs_cnt - hs0 < 300 && n < 2000) begin
            for (int i = 0; i < 4; i++) pk[i] = {2'(i), 2'b11, 32'($urandom())};
            cyc();
            n++;
        end
        in_valid = '0;
        repeat (6) cyc();
        check("sat grants", 64'(hs_cnt - hs0 >= 300), 64'd1);
        check("sat err_cnt", 64'(err_cnt), 64'hFF);

        // reset while out_valid is high
        out_ready = 1'b0;
        pk[1]     = {2'd1, 2'b10, 32'hDEAD_BEEF};
        in_valid  = 4'b0010;
        cyc();
        in_valid = '0;
        wait_out_valid(5);
        pulse_reset();
        cyc();
        out_ready = 1'b1;
        repeat (4) begin
            check("post-reset idle", 64'(out_valid), 64'd0);
            cyc();
        end
        pk[3]    = {2'd3, 2'b00, 32'h1234_5678};
        in_valid = 4'b1000;
        cyc();
        in_valid = '0;
        cyc();
        check("post-reset first valid", 64'(out_valid), 64'd1);
        check("post-reset first src", 64'(out_src), 64'd3);

        // randomized traffic with random backpressure
        pulse_reset();
        cyc();
        repeat (400) begin
            in_valid = 4'($urandom());
            for (int i = 0; i < 4; i++) pk[i] = {4'($urandom()), 32'($urandom())};
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (10) cyc();
        check("drain queue", 64'(exp_q.size()), 64'd0);
        check("drain out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 The block SHALL have parameter PKT_W, default 36, giving the packet width: tag[35:34], resp[33:32], data[31:0].
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 4 bits: per-port packet-valid (bit i = port i+1).
REQ-005 The block SHALL have ports in_pkt_port1..in_pkt_port4, input, PKT_W bits each: per-port packet.
REQ-006 The block SHALL have port in_ready, output, 4 bits: per-port slot-empty; an input transfers when in_valid[i] & in_ready[i] at a clk edge.
REQ-007 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_pkt holds a packet.
REQ-009 The block SHALL have port out_pkt, output, PKT_W bits: forwarded packet.
REQ-010 The block SHALL have port out_src, output, 2 bits: source port of out_pkt (0 = port1 .. 3 = port4).
REQ-011 The block SHALL have port err_cnt, output, 8 bits: saturating count of forwarded packets with resp != 2'b00.

Function
REQ-012 The block SHALL hold a 1-deep slot per port; in_ready[i] SHALL equal !slot_full[i], driven from registers only, with no combinational path from in_valid.
REQ-013 A transfer SHALL set slot_full[i] and store the packet; an input transfer that is not accepted SHALL leave the slot unchanged.
REQ-014 The FSM SHALL have exactly two states, IDLE (out_valid=0) and SEND (out_valid=1).
REQ-015 The output register SHALL be "free" in IDLE, or in SEND when out_ready=1.
REQ-016 On each edge where the output register is free and any slot is full, the block SHALL grant one slot.
  - Grant: load out_pkt and out_src, clear that slot, update last_grant, state becomes SEND.
REQ-017 On each edge where the output register is free and no slot is full, the state SHALL become IDLE.
REQ-018 In SEND with out_ready=0, out_pkt, out_src and out_valid SHALL be held stable.
REQ-019 Arbitration SHALL be round-robin: search order starts at last_grant+1 mod 4 and wraps; the first full slot wins.
REQ-020 A slot being granted SHALL NOT accept a new packet on the same edge, since its in_ready was 0.
  - The slot becomes writable one cycle later.
REQ-021 Minimum latency SHALL be 2 edges: captured at edge N, out_valid=1 after edge N+1.
REQ-022 Sustained throughput SHALL be 1 packet per clock while out_ready=1 and slots stay full.
REQ-023 On each grant with resp field != 2'b00, err_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-024 Packet contents SHALL pass unmodified, bit-exact, from input to out_pkt.
REQ-025 Each accepted packet SHALL appear on out_pkt exactly once; no drop or duplication.

Reset
REQ-026 On rst_n=0 (asynchronous), the block SHALL immediately reach its reset state:
  - state=IDLE, out_valid=0, out_pkt=0, out_src=0, err_cnt=0
  - all slot_full=0, so in_ready=4'hF
  - last_grant=3, so port1 has first priority
REQ-027 Reset asserted mid-operation SHALL discard all slot and output packets, with no output after release until new input.
REQ-028 After rst_n deasserts, the first transfer SHALL be accepted at the first rising edge with in_valid=1.

Verification
REQ-029 The bench SHALL cover single packet:
  - stimulus: port3 sends 36'h1_0000_ABCD (tag0, resp1), out_ready=1
  - response: out_valid high 2 edges later for 1 cycle; out_pkt=36'h1_0000_ABCD, out_src=2, err_cnt=1
REQ-030 The bench SHALL cover round-robin:
  - stimulus: all four ports load one packet simultaneously after reset, out_ready=1
  - response: out_src sequence 0,1,2,3 on consecutive cycles; in_ready[i] returns to 1 one cycle after each grant
REQ-031 The bench SHALL cover backpressure:
  - stimulus: out_ready=0 for 5 cycles with port1 and port2 loaded
  - response: out_pkt/out_src stable at port1's packet; in_ready=4'b1100; after out_ready=1, port2 follows on the next cycle
REQ-032 The bench SHALL cover fairness:
  - stimulus: port1 and port4 continuously valid, out_ready=1
  - response: out_src alternates 0,3,0,3; neither port is granted twice in a row
REQ-033 The bench SHALL cover err_cnt saturation:
  - stimulus: 300 packets with resp=2'b11
  - response: err_cnt=8'hFF and no wrap to 0
REQ-034 The bench SHALL cover reset mid-SEND:
  - stimulus: rst_n pulsed low between edges while out_valid=1
  - response: out_valid=0 and in_ready=4'hF immediately; no stale packet emitted after release
